pattern_serializer: RTL and testbench

PATTERN_SERIALIZER -- requirements
Module: pattern_serializer

---
 rtl/pattern_pkg.sv | 20 ++
 rtl/pattern_serializer.sv | 108 ++++++++++
 tb/tb_pattern_serializer.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pattern_pkg.sv
// Shared type definitions for the pattern serializer and the downstream
// pattern recognizer.
package pattern_pkg;

  // Two spare encodings exist so that an illegal state is detectable.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01
  } ser_state_e;

  // States of the downstream 1101 recognizer.
  typedef enum logic [2:0] {
    REC_S0    = 3'd0,
    REC_S1    = 3'd1,
    REC_S11   = 3'd2,
    REC_S110  = 3'd3,
    REC_S1101 = 3'd4
  } rec_state_e;

endpackage

// File: rtl/pattern_serializer.sv
// Parallel-to-serial converter with valid/ready intake and a shift enable,
// feeding one bit per enabled cycle to a downstream pattern recognizer.
module pattern_serializer
  import pattern_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             en,
  output logic             a,
  output logic             a_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  ser_state_e       r_state;
  ser_state_e       w_next;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic             w_head;
  logic [WIDTH-1:0] w_shifted;
  logic             w_load;
  logic             w_shift;
  logic             w_last;

  assign w_head    = (MSB_FIRST != 0) ? r_shift[WIDTH-1] : r_shift[0];
  assign w_shifted = (MSB_FIRST != 0) ? {r_shift[WIDTH-2:0], 1'b0}
                                      : {1'b0, r_shift[WIDTH-1:1]};
  assign w_last    = (r_cnt == '0);

  // Next-state, handshake and serial output decode.
  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_shift   = 1'b0;
    in_ready  = 1'b0;
    a         = 1'b0;
    a_valid   = 1'b0;
    word_done = 1'b0;
    busy      = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_load = 1'b1;
          w_next = SHIFT;
        end else begin
          w_next = IDLE;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        a    = w_head;
        if (en) begin
          a_valid = 1'b1;
          w_shift = 1'b1;
          if (w_last) begin
            // Last bit: accepting the next word here keeps the stream gap-free.
            word_done = 1'b1;
            in_ready  = 1'b1;
            if (in_valid) begin
              w_load = 1'b1;
              w_next = SHIFT;
            end else begin
              w_next = IDLE;
            end
          end else begin
            w_next = SHIFT;
          end
        end else begin
          w_next = SHIFT;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // State, shift register and bit counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_shift <= in_data;
        r_cnt   <= CNT_LOAD;
      end else if (w_shift) begin
        r_shift <= w_shifted;
        if (!w_last) begin
          r_cnt <= r_cnt - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pattern_serializer.sv
// Scoreboard bench for pattern_serializer: an MSB-first and an LSB-first
// instance share all inputs; expected bits are queued at each handshake.
module tb_pattern_serializer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       en = 1'b1;
  logic       in_ready, a, a_valid, word_done, busy;
  logic       l_in_ready, l_a, l_a_valid, l_word_done, l_busy;

  int checks = 0;
  int failures = 0;

  // Each entry: {expected bit, expected word_done}.
  logic [1:0] q_m[$];
  logic [1:0] q_l[$];

  always #5 clk = ~clk;

  pattern_serializer #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .en(en), .a(a), .a_valid(a_valid),
    .word_done(word_done), .busy(busy)
  );

  pattern_serializer #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(l_in_ready), .en(en), .a(l_a), .a_valid(l_a_valid),
    .word_done(l_word_done), .busy(l_busy)
  );

  task automatic push_word(input logic [7:0] d);
    for (int i = 0; i < 8; i++) begin
      q_m.push_back({d[7-i], (i == 7)});
      q_l.push_back({d[i], (i == 7)});
    end
  endtask

  // Record a handshake if one happens at the coming edge, then advance.
  task automatic cycle();
    if (!reset && in_valid && in_ready) push_word(in_data);
    @(posedge clk);
    @(negedge clk);
    #2;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({a, a_valid, word_done, busy, l_a, l_a_valid, l_busy} !== 7'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=0000000",
               {a, a_valid, word_done, busy, l_a, l_a_valid, l_busy});
    end
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({in_ready, l_in_ready} !== 2'b11) begin
      failures++;
      $display("FAIL reset_ready got=%b want=11", {in_ready, l_in_ready});
    end
    cycle();
  endtask

  task automatic test_idle();
    in_valid = 1'b0;
    for (int j = 0; j < 10; j++) begin
      #1;
      checks++;
      if ({a, a_valid, in_ready, busy} !== 4'b0010) begin
        failures++;
        $display("FAIL idle_outputs cyc=%0d got=%b want=0010", j, {a, a_valid, in_ready, busy});
      end
      cycle();
    end
  endtask

  task automatic test_single();
    logic [1:0] em, el;
    in_data = 8'hD0;
    in_valid = 1'b1;
    #1;
    cycle();
    in_valid = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      #1;
      em = q_m.pop_front();
      el = q_l.pop_front();
      checks++;
      if ({a_valid, a, word_done} !== {1'b1, em}) begin
        failures++;
        $display("FAIL single_msb cyc=%0d got=%b want=%b", j, {a_valid, a, word_done}, {1'b1, em});
      end
      checks++;
      if ({l_a_valid, l_a, l_word_done} !== {1'b1, el}) begin
        failures++;
        $display("FAIL single_lsb cyc=%0d got=%b want=%b", j, {l_a_valid, l_a, l_word_done}, {1'b1, el});
      end
      cycle();
    end
    #1;
    checks++;
    if ({busy, a_valid, a, in_ready} !== 4'b0001) begin
      failures++;
      $display("FAIL single_after got=%b want=0001", {busy, a_valid, a, in_ready});
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  em, el;
    logic [3:0]  hist;
    logic [15:0] stream;
    int          rec_cnt, rec_exp;
    hist = 4'b0000;
    rec_cnt = 0;
    rec_exp = 0;
    stream = {8'hD0, 8'hDD};
    for (int k = 0; k <= 12; k++) begin
      if (stream[15-k -: 4] == 4'b1101) rec_exp++;
    end
    in_data = 8'hD0;
    in_valid = 1'b1;
    #1;
    cycle();
    in_data = 8'hDD;
    for (int j = 1; j <= 16; j++) begin
      #1;
      if (q_m.size() == 0 || q_l.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL b2b_underflow cyc=%0d got=empty want=bit", j);
      end else begin
        em = q_m.pop_front();
        el = q_l.pop_front();
        checks++;
        if ({a_valid, a, word_done, l_a_valid, l_a, l_word_done} !== {1'b1, em, 1'b1, el}) begin
          failures++;
          $display("FAIL b2b_bit cyc=%0d got=%b want=%b", j,
                   {a_valid, a, word_done, l_a_valid, l_a, l_word_done}, {1'b1, em, 1'b1, el});
        end
      end
      if (a_valid) begin
        hist = {hist[2:0], a};
        if (hist == 4'b1101) rec_cnt++;
      end
      if (j <= 8) begin
        checks++;
        if (in_ready !== (j == 8)) begin
          failures++;
          $display("FAIL b2b_ready cyc=%0d got=%b want=%b", j, in_ready, (j == 8));
        end
      end
      cycle();
      if (j == 8) in_valid = 1'b0;
    end
    checks++;
    if (rec_cnt != rec_exp) begin
      failures++;
      $display("FAIL b2b_pattern got=%0d want=%0d", rec_cnt, rec_exp);
    end
    #1;
    checks++;
    if ({busy, a_valid} !== 2'b00) begin
      failures++;
      $display("FAIL b2b_after got=%b want=00", {busy, a_valid});
    end
  endtask

  task automatic test_stall();
    logic [1:0] em, el;
    int         done_cyc;
    done_cyc = 0;
    in_data = 8'hD0;
    in_valid = 1'b1;
    #1;
    cycle();
    in_valid = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      en = !(j == 3 || j == 4);
      #1;
      if (word_done) done_cyc = j;
      if (!en) begin
        checks++;
        if ({a_valid, word_done, a, l_a_valid, l_a} !== {2'b00, q_m[0][1], 1'b0, q_l[0][1]}) begin
          failures++;
          $display("FAIL stall_hold cyc=%0d got=%b want=%b", j,
                   {a_valid, word_done, a, l_a_valid, l_a}, {2'b00, q_m[0][1], 1'b0, q_l[0][1]});
        end
      end else begin
        em = q_m.pop_front();
        el = q_l.pop_front();
        checks++;
        if ({a_valid, a, word_done, l_a_valid, l_a, l_word_done} !== {1'b1, em, 1'b1, el}) begin
          failures++;
          $display("FAIL stall_bit cyc=%0d got=%b want=%b", j,
                   {a_valid, a, word_done, l_a_valid, l_a, l_word_done}, {1'b1, em, 1'b1, el});
        end
      end
      cycle();
    end
    en = 1'b1;
    checks++;
    if (done_cyc != 10) begin
      failures++;
      $display("FAIL stall_done got=%0d want=10", done_cyc);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] em, el;
    in_data = 8'hD0;
    in_valid = 1'b1;
    #1;
    cycle();
    in_valid = 1'b0;
    repeat (3) begin
      void'(q_m.pop_front());
      void'(q_l.pop_front());
      cycle();
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({a, a_valid, busy, word_done, l_a, l_a_valid, l_busy} !== 7'b0) begin
      failures++;
      $display("FAIL midreset_async got=%b want=0000000",
               {a, a_valid, busy, word_done, l_a, l_a_valid, l_busy});
    end
    q_m.delete();
    q_l.delete();
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({in_ready, l_in_ready} !== 2'b11) begin
      failures++;
      $display("FAIL midreset_ready got=%b want=11", {in_ready, l_in_ready});
    end
    in_data = 8'hDD;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      #1;
      em = q_m.pop_front();
      el = q_l.pop_front();
      checks++;
      if ({a_valid, a, word_done, l_a_valid, l_a, l_word_done} !== {1'b1, em, 1'b1, el}) begin
        failures++;
        $display("FAIL midreset_word cyc=%0d got=%b want=%b", j,
                 {a_valid, a, word_done, l_a_valid, l_a, l_word_done}, {1'b1, em, 1'b1, el});
      end
      cycle();
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] pat;
    logic [1:0] el;
    pat = 8'b1101_0000;
    in_data = 8'h0B;
    in_valid = 1'b1;
    #1;
    cycle();
    in_valid = 1'b0;
    for (int j = 0; j < 8; j++) begin
      #1;
      void'(q_m.pop_front());
      el = q_l.pop_front();
      checks++;
      if ({l_a_valid, l_a, l_word_done} !== {1'b1, pat[7-j], el[0]} || l_a !== el[1]) begin
        failures++;
        $display("FAIL lsb_bit cyc=%0d got=%b want=%b", j + 1,
                 {l_a_valid, l_a, l_word_done}, {1'b1, pat[7-j], el[0]});
      end
      cycle();
    end
    checks++;
    if (q_m.size() != 0 || q_l.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_left got=%0d want=0", q_m.size() + q_l.size());
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_lsb_first();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
